branch_seq: RTL and testbench

Branch-instruction sequencer for the bus-architecture CPU. On a start request it runs the conditional-branch microsequence: it drives Ra onto the bus, fires the single-cycle enable that clocks the CON flip-flop, and computes PC + C through Y/ALU/Z. It then writes Z back into PC only when the CON flag is set. It sits beside the main control unit, which hands over bus control for the duration of a branch.

---
 rtl/branch_seq.sv | 128 ++++++++++++
 tb/tb_branch_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq.sv
// branch_seq: conditional-branch microsequencer (Ra -> CON, PC + C -> Z, Z -> PC when CON set).
// Defining BRANCH_STATS_EN adds saturating taken/not-taken counters with a synchronous clear.
module branch_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             con_q,
    output logic             gra,
    output logic             r_out,
    output logic             con_in,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic             alu_add,
    output logic             z_in,
    output logic             zlo_out,
    output logic             pc_in,
    output logic             busy,
    output logic             done,
    output logic             taken
`ifdef BRANCH_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, RA, CON, PC, ADD, DECIDE, WB, DONE
    } state_t;

    typedef struct packed {
        logic gra;
        logic r_out;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic alu_add;
        logic z_in;
        logic zlo_out;
        logic pc_in;
        logic busy;
        logic done;
    } strobe_t;

    state_t  state, next_state;
    strobe_t strb, next_strb;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        next_strb  = '0;

        case (state)
            IDLE:    if (start) next_state = RA;
            RA:      next_state = CON;
            CON:     next_state = PC;
            PC:      next_state = ADD;
            ADD:     next_state = DECIDE;
            DECIDE:  next_state = con_q ? WB : DONE;
            WB:      next_state = DONE;
            DONE:    next_state = start ? RA : IDLE;
            default: next_state = IDLE;
        endcase

        // Strobes are decoded from the next state and registered, so they are glitch-free.
        case (next_state)
            RA:      begin next_strb.gra = 1'b1; next_strb.r_out = 1'b1; end
            CON:     begin next_strb.gra = 1'b1; next_strb.r_out = 1'b1; next_strb.con_in = 1'b1; end
            PC:      begin next_strb.pc_out = 1'b1; next_strb.y_in = 1'b1; end
            ADD:     begin next_strb.c_out = 1'b1; next_strb.alu_add = 1'b1; next_strb.z_in = 1'b1; end
            WB:      begin next_strb.zlo_out = 1'b1; next_strb.pc_in = 1'b1; end
            DONE:    next_strb.done = 1'b1;
            default: ;
        endcase
        next_strb.busy = (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!clr_n) begin
            state <= IDLE;
            strb  <= '0;
            taken <= 1'b0;
        end else begin
            state <= next_state;
            strb  <= next_strb;
            if (state == DECIDE) taken <= con_q;
        end
    end

    assign gra     = strb.gra;
    assign r_out   = strb.r_out;
    assign con_in  = strb.con_in;
    assign pc_out  = strb.pc_out;
    assign y_in    = strb.y_in;
    assign c_out   = strb.c_out;
    assign alu_add = strb.alu_add;
    assign z_in    = strb.z_in;
    assign zlo_out = strb.zlo_out;
    assign pc_in   = strb.pc_in;
    assign busy    = strb.busy;
    assign done    = strb.done;

`ifdef BRANCH_STATS_EN
    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            taken_cnt  <= '0;
            ntaken_cnt <= '0;
        end else if (stats_clr) begin
            taken_cnt  <= '0;
            ntaken_cnt <= '0;
        end else if (state == DECIDE) begin
            if (con_q) begin
                if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
            end else begin
                if (ntaken_cnt != '1) ntaken_cnt <= ntaken_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: table-driven branch model, per-cycle compare, directed timing checks.
// Counter checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_seq;

    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic start = 1'b0;
    logic con_q = 1'b0;
    logic stats_clr = 1'b0;
    logic gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in, busy, done, taken;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt, ntaken_cnt;
`endif

    int errors = 0;
    int checks = 0;

    branch_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .con_q(con_q),
        .gra(gra), .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
        .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .zlo_out(zlo_out), .pc_in(pc_in),
        .busy(busy), .done(done), .taken(taken)
`ifdef BRANCH_STATS_EN
        , .stats_clr(stats_clr), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe word per microstep {gra,r_out,con_in,pc_out,y_in,c_out,alu_add,z_in,zlo_out,pc_in,busy,done}.
    // Index: 0 RA, 1 CON, 2 PC, 3 ADD, 4 DECIDE, 5 WB, 6 DONE.
    logic [11:0] seq [7];
    initial begin
        seq[0] = 12'b1100_0000_0010;
        seq[1] = 12'b1110_0000_0010;
        seq[2] = 12'b0001_1000_0010;
        seq[3] = 12'b0000_0111_0010;
        seq[4] = 12'b0000_0000_0010;
        seq[5] = 12'b0000_0000_1110;
        seq[6] = 12'b0000_0000_0011;
    end

    // Reference model: a queue of remaining microsteps for the branch in flight.
    int               q[$];
    int               cur_idx = -1;
    logic             next_con = 1'b0;
    logic             pend_con = 1'b0;
    logic             m_taken = 1'b0;
    logic [CNT_W-1:0] m_tcnt = '0;
    logic [CNT_W-1:0] m_ncnt = '0;

    initial begin
        forever begin
            @(posedge clk or negedge clr_n);
            if (!clr_n) begin
                q.delete();
                cur_idx = -1;
                m_taken = 1'b0;
                m_tcnt  = '0;
                m_ncnt  = '0;
            end else begin
                if (stats_clr) begin
                    m_tcnt = '0;
                    m_ncnt = '0;
                end else if (cur_idx == 4) begin
                    if (pend_con && m_tcnt != '1) m_tcnt = m_tcnt + 1'b1;
                    if (!pend_con && m_ncnt != '1) m_ncnt = m_ncnt + 1'b1;
                end
                if (cur_idx == 4) m_taken = pend_con;
                if (q.size() == 0 && start) begin
                    pend_con = next_con;
                    for (int i = 0; i < 7; i++)
                        if (i != 5 || next_con) q.push_back(i);
                end
                cur_idx = (q.size() != 0) ? q.pop_front() : -1;
            end
        end
    end

    // CON flip-flop stand-in: takes the branch's condition during the con_in pulse, noise while idle.
    initial begin
        forever begin
            @(negedge clk);
            if (cur_idx == 1) con_q = pend_con;
            else if (cur_idx < 0) con_q = 1'($urandom);
        end
    end

    // Per-cycle compare against the model, plus bus exclusivity and one con_in pulse per branch.
    int   con_pulses = 0;
    logic prev_con = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            check("strobes", 32'({gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in, busy, done}),
                  32'((cur_idx < 0) ? 12'h000 : seq[cur_idx]));
            check("taken", 32'(taken), 32'(m_taken));
            check("bus_exclusive", 32'($countones({r_out, pc_out, c_out, zlo_out}) <= 1), 32'd1);
`ifdef BRANCH_STATS_EN
            check("taken_cnt", 32'(taken_cnt), 32'(m_tcnt));
            check("ntaken_cnt", 32'(ntaken_cnt), 32'(m_ncnt));
`endif
            if (!clr_n) con_pulses = 0;
            else if (con_in && !prev_con) con_pulses++;
            if (done) begin
                check("con_pulses_per_branch", 32'(con_pulses), 32'd1);
                con_pulses = 0;
            end
            prev_con = con_in;
        end
    end

    // One start pulse; records cycle numbers (relative to the accepting edge) of the key strobes.
    task automatic run_one(input logic con, output int con_first, output int con_n,
                           output int pcin_cyc, output int done_cyc, output logic tk);
        con_first = 0; con_n = 0; pcin_cyc = 0; done_cyc = 0; tk = 1'b0;
        @(negedge clk);
        next_con = con;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (con_in) begin
                con_n++;
                if (con_first == 0) con_first = k;
            end
            if (pc_in && pcin_cyc == 0) pcin_cyc = k;
            if (done && done_cyc == 0) begin
                done_cyc = k;
                tk = taken;
            end
        end
    endtask

    int   c_first, c_n, c_pc, c_done, n_done, first_done;
    logic c_tk, ra2, exp_con;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", 32'({gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in, busy, done, taken}), 32'd0);
        clr_n = 1'b1;

        // Taken branch, first start right after reset release.
        run_one(1'b1, c_first, c_n, c_pc, c_done, c_tk);
        check("taken_con_in_cycle", 32'(c_first), 32'd2);
        check("taken_con_in_width", 32'(c_n), 32'd1);
        check("taken_pc_in_cycle", 32'(c_pc), 32'd6);
        check("taken_done_cycle", 32'(c_done), 32'd7);
        check("taken_flag", 32'(c_tk), 32'd1);

        // Not-taken branch.
        run_one(1'b0, c_first, c_n, c_pc, c_done, c_tk);
        check("ntaken_con_in_cycle", 32'(c_first), 32'd2);
        check("ntaken_pc_in_never", 32'(c_pc), 32'd0);
        check("ntaken_done_cycle", 32'(c_done), 32'd6);
        check("ntaken_flag", 32'(c_tk), 32'd0);

        // start re-asserted in cycles 2-5 is ignored.
        @(negedge clk);
        next_con = 1'b1;
        start = 1'b1;
        @(posedge clk);
        n_done = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = (k >= 2 && k <= 5);
            if (done) n_done++;
        end
        check("busy_start_single_done", 32'(n_done), 32'd1);

        // start held high: next RA directly follows DONE.
        @(negedge clk);
        exp_con = 1'($urandom);
        next_con = exp_con;
        start = 1'b1;
        @(posedge clk);
        first_done = 0;
        ra2 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) next_con = 1'($urandom);
            if (first_done != 0 && k == first_done + 1) ra2 = gra && r_out && !con_in && busy;
            if (done && first_done == 0) first_done = k;
        end
        check("held_first_done_cycle", 32'(first_done), exp_con ? 32'd7 : 32'd6);
        check("held_back_to_back_ra", 32'(ra2), 32'd1);
        start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12 && busy; k++) begin
            @(negedge clk);
            n_done++;
        end
        check("held_returns_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of ADD.
        @(negedge clk);
        next_con = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_in_add", 32'({c_out, alu_add, z_in}), 32'h7);
        #2 clr_n = 1'b0;
        #1 check("async_reset_outputs", 32'({gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in, busy, done, taken}), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        run_one(1'b1, c_first, c_n, c_pc, c_done, c_tk);
        check("post_reset_con_in_cycle", 32'(c_first), 32'd2);
        check("post_reset_pc_in_cycle", 32'(c_pc), 32'd6);
        check("post_reset_done_cycle", 32'(c_done), 32'd7);

`ifdef BRANCH_STATS_EN
        // Fresh counters, four taken branches saturate a 2-bit counter at 3.
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        repeat (4) run_one(1'b1, c_first, c_n, c_pc, c_done, c_tk);
        check("stats_taken_saturated", 32'(taken_cnt), 32'd3);
        check("stats_ntaken_zero", 32'(ntaken_cnt), 32'd0);
        // Clear in the DECIDE cycle beats the increment.
        @(negedge clk);
        next_con = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            stats_clr = (k == 5);
        end
        check("stats_clr_taken", 32'(taken_cnt), 32'd0);
        check("stats_clr_ntaken", 32'(ntaken_cnt), 32'd0);
        repeat (4) @(negedge clk);
`endif

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            next_con = 1'($urandom);
            stats_clr = ($urandom_range(0, 15) == 0);
        end
        start = 1'b0;
        stats_clr = 1'b0;
        repeat (12) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
